// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute sequencer for an 8-bit accumulator CPU
//
// Purpose: steps instructions through IDLE, FETCH, DECODE, OPER, EXEC and HALT.
// It issues memory reads at the externally held program counter, latches the
// opcode and operand, and strobes the PC and accumulator controls.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   run               1 = keep executing, 0 = stop at the next instruction boundary
//   pc_value          current program counter (owned outside this block)
//   mem_rdata/mem_ack read data and its completion strobe
//   alu_zero          accumulator-zero flag, used by JZ
//   mem_req/mem_addr  read request and address (only in FETCH/OPER)
//   pc_inc/pc_load    one-cycle PC strobes; pc_dat is the load value
//   ir/operand        instruction and operand registers
//   acc_we/alu_op     one-cycle accumulator write and ALU select
//   halted            high in HALT
//   mem_err           read timeout flag (only when SEQ_TIMEOUT_EN is defined)
//
// Build option: SEQ_TIMEOUT_EN adds a 15-cycle read timeout that halts with mem_err.

module cpu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] pc_value,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    input  logic       alu_zero,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [7:0] pc_dat,
    output logic [7:0] ir,
    output logic [7:0] operand,
    output logic       acc_we,
    output logic [1:0] alu_op,
    output logic       halted
`ifdef SEQ_TIMEOUT_EN
    ,
    output logic       mem_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_OPER   = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LDI = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] operand_q, operand_d;
    logic [3:0] opcode;

`ifdef SEQ_TIMEOUT_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;
`endif

    assign opcode = ir_q[7:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ir_q       <= 8'h00;
            operand_q  <= 8'h00;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt_q <= 4'd0;
            mem_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            operand_q  <= operand_d;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
`endif
        end
    end

    // All strobes are decoded from the registered state, so an asynchronous
    // reset (state forced to IDLE) drops them, including mem_req, immediately.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        operand_d = operand_q;
        mem_req   = 1'b0;
        mem_addr  = 8'h00;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_dat    = 8'h00;
        acc_we    = 1'b0;
        alu_op    = 2'b00;
`ifdef SEQ_TIMEOUT_EN
        // Counter stays zero outside a wait, so every entry to FETCH/OPER starts fresh.
        wait_cnt_d = 4'd0;
        mem_err_d  = mem_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end

            S_FETCH, S_OPER: begin
                mem_req  = 1'b1;
                mem_addr = pc_value;
                if (mem_ack) begin
                    pc_inc = 1'b1;
                    if (state_q == S_FETCH) begin
                        ir_d    = mem_rdata;
                        state_d = S_DECODE;
                    end else begin
                        operand_d = mem_rdata;
                        state_d   = S_EXEC;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                // wait_cnt_q counts earlier unanswered cycles; this is the 15th.
                else if (wait_cnt_q == 4'd14) begin
                    state_d   = S_HALT;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
`endif
            end

            S_DECODE: begin
                if (opcode >= OP_ADD && opcode <= OP_JZ) state_d = S_OPER;
                else                                     state_d = S_EXEC;
            end

            S_EXEC: begin
                case (opcode)
                    OP_ADD: begin acc_we = 1'b1; alu_op = 2'b01; end
                    OP_SUB: begin acc_we = 1'b1; alu_op = 2'b10; end
                    OP_LDI: begin acc_we = 1'b1; alu_op = 2'b00; end
                    OP_JMP: begin pc_load = 1'b1; pc_dat = operand_q; end
                    OP_JZ: begin
                        if (alu_zero) begin
                            pc_load = 1'b1;
                            pc_dat  = operand_q;
                        end
                    end
                    default: ;
                endcase
                // run is only consulted here, so a mid-instruction stop completes the instruction.
                if (opcode == OP_HLT) state_d = S_HALT;
                else if (run)         state_d = S_FETCH;
                else                  state_d = S_IDLE;
            end

            S_HALT: ;

            default: state_d = S_IDLE;
        endcase
    end

    assign ir      = ir_q;
    assign operand = operand_q;
    assign halted  = (state_q == S_HALT);
`ifdef SEQ_TIMEOUT_EN
    assign mem_err = mem_err_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard testbench for cpu_sequencer

module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst, run, mem_ack, alu_zero;
    logic [7:0] pc_value, mem_rdata;
    logic       mem_req, pc_inc, pc_load, acc_we, halted;
    logic [7:0] mem_addr, pc_dat, ir, operand;
    logic [1:0] alu_op;
`ifdef SEQ_TIMEOUT_EN
    logic       mem_err;
`endif

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .pc_value(pc_value),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_zero(alu_zero),
        .mem_req(mem_req), .mem_addr(mem_addr), .pc_inc(pc_inc),
        .pc_load(pc_load), .pc_dat(pc_dat), .ir(ir), .operand(operand),
        .acc_we(acc_we), .alu_op(alu_op), .halted(halted)
`ifdef SEQ_TIMEOUT_EN
        , .mem_err(mem_err)
`endif
    );

    int          n_checks = 0;
    int          n_err = 0;
    logic [7:0]  mem [256];
    logic [11:0] sb [$];
    int          ack_delay, wait_cnt, inc_cnt, cyc_idx, first_acc;
    logic [7:0]  acc_m, first_ir, first_opd, s_addr, seen_dat;
    int          first_inc;
    logic        seen_inc, seen_load, s_req;
    int          req_cycles;
    logic        addr_ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ev_acc(input logic [1:0] op, input logic [7:0] d);
        return {2'd1, op, d};
    endfunction

    function automatic logic [11:0] ev_load(input logic [7:0] d);
        return {2'd2, 2'b00, d};
    endfunction

    task automatic respond();
        if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                wait_cnt  = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'hA5;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic monitor();
        logic [11:0] exp_ev;
        seen_inc  = pc_inc;
        seen_load = pc_load;
        seen_dat  = pc_dat;
        s_req     = mem_req;
        s_addr    = mem_addr;
        if (pc_inc || pc_load) check("inc_load_excl", 32'(pc_inc & pc_load), 0);
        if (pc_inc) inc_cnt++;
        if (acc_we) begin
            if (first_acc < 0) begin
                first_acc = cyc_idx;
                first_ir  = ir;
                first_opd = operand;
                first_inc = inc_cnt;
            end
            check("sb_has_acc", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_ev = sb.pop_front();
                check("acc_event", 32'(ev_acc(alu_op, operand)), 32'(exp_ev));
            end
            case (alu_op)
                2'b00:   acc_m = operand;
                2'b01:   acc_m = acc_m + operand;
                2'b10:   acc_m = acc_m - operand;
                default: ;
            endcase
        end
        if (pc_load) begin
            check("sb_has_load", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_ev = sb.pop_front();
                check("load_event", 32'(ev_load(pc_dat)), 32'(exp_ev));
            end
        end
    endtask

    // One clock: answer memory, sample at negedge+1, then update the PC model after posedge.
    task automatic cycle();
        @(negedge clk);
        respond();
        #1;
        monitor();
        @(posedge clk);
        #1;
        if (seen_load)     pc_value = seen_dat;
        else if (seen_inc) pc_value = pc_value + 8'd1;
        alu_zero = (acc_m == 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        pc_value = 8'h00;
        acc_m = 8'h01;
        alu_zero = 1'b0;
        wait_cnt = 0;
        inc_cnt = 0;
        first_acc = -1;
        sb.delete();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        run = 1'b0;
        pc_value = 8'h00;
        mem_rdata = 8'h00;
        mem_ack = 1'b0;
        alu_zero = 1'b0;
        ack_delay = 0;
        cyc_idx = 0;
        #1 rst = 1'b1;
        #1;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_pc_inc", 32'(pc_inc), 0);
        check("rst_pc_load", 32'(pc_load), 0);
        check("rst_acc_we", 32'(acc_we), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_ir", 32'(ir), 0);
        check("rst_operand", 32'(operand), 0);
        check("rst_pc_dat", 32'(pc_dat), 0);
        check("rst_alu_op", 32'(alu_op), 0);

        // Program: LDI 5, ADD 3, SUB 1, NOP, 0x70, JMP 10; JZ 20 (not taken), LDI 0, JZ 30 (taken); HLT
        do_reset();
        mem[8'h00] = 8'h31; mem[8'h01] = 8'h05;
        mem[8'h02] = 8'h11; mem[8'h03] = 8'h03;
        mem[8'h04] = 8'h22; mem[8'h05] = 8'h01;
        mem[8'h06] = 8'h00; mem[8'h07] = 8'h70;
        mem[8'h08] = 8'h40; mem[8'h09] = 8'h10;
        mem[8'h10] = 8'h50; mem[8'h11] = 8'h20;
        mem[8'h12] = 8'h31; mem[8'h13] = 8'h00;
        mem[8'h14] = 8'h50; mem[8'h15] = 8'h30;
        mem[8'h30] = 8'hF0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("idle_hold_req", 32'(s_req), 0);
        end
        sb.push_back(ev_acc(2'b00, 8'h05));
        sb.push_back(ev_acc(2'b01, 8'h03));
        sb.push_back(ev_acc(2'b10, 8'h01));
        sb.push_back(ev_load(8'h10));
        sb.push_back(ev_acc(2'b00, 8'h00));
        sb.push_back(ev_load(8'h30));
        ack_delay = 0;
        run = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cyc_idx = i;
            cycle();
            if (halted) break;
        end
        check("main_halted", 32'(halted), 1);
        check("first_acc_cycle", first_acc, 4);
        check("first_ir", 32'(first_ir), 32'h31);
        check("first_operand", 32'(first_opd), 32'h05);
        check("first_inc_count", first_inc, 2);
        check("sb_drained", sb.size(), 0);
        check("final_pc", 32'(pc_value), 32'h31);
        check("halt_ir", 32'(ir), 32'hF0);
        for (int k = 0; k < 6; k++) begin
            run = k[0];
            cycle();
            check("halt_sticky", 32'(halted), 1);
            check("halt_no_req", 32'(s_req), 0);
        end
        rst = 1'b1;
        #1;
        check("rst_leaves_halt", 32'(halted), 0);

        // Delayed ack: 7 request cycles on the first fetch, exactly one pc_inc.
        do_reset();
        ack_delay = 6;
        req_cycles = 0;
        addr_ok = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (s_req) begin
                req_cycles++;
                if (s_addr != 8'h00) addr_ok = 1'b0;
            end
            if (inc_cnt > 0) break;
        end
        check("wait_req_cycles", req_cycles, 7);
        check("wait_addr_stable", 32'(addr_ok), 1);
        cycle();
        cycle();
        check("wait_single_inc", inc_cnt, 1);
        check("wait_pc", 32'(pc_value), 1);

        // Reset pulse in OPER drops mem_req without a clock edge.
        do_reset();
        mem[8'h00] = 8'h31;
        mem[8'h01] = 8'h05;
        ack_delay = 3;
        run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (inc_cnt > 0) break;
        end
        cycle();
        @(negedge clk);
        respond();
        #1;
        check("oper_req", 32'(mem_req), 1);
        check("oper_addr", 32'(mem_addr), 1);
        rst = 1'b1;
        #1;
        check("oper_rst_req", 32'(mem_req), 0);
        check("oper_rst_inc", 32'(pc_inc), 0);
        check("oper_rst_load", 32'(pc_load), 0);
        check("oper_rst_acc_we", 32'(acc_we), 0);
        check("oper_rst_ir", 32'(ir), 0);
        check("oper_rst_operand", 32'(operand), 0);
        check("oper_rst_halted", 32'(halted), 0);
        run = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check("post_rst_idle", 32'(s_req), 0);

`ifdef SEQ_TIMEOUT_EN
        do_reset();
        ack_delay = 1000;
        req_cycles = 0;
        run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (s_req) req_cycles++;
            if (halted) break;
        end
        check("to_req_cycles", req_cycles, 15);
        check("to_halted", 32'(halted), 1);
        check("to_mem_err", 32'(mem_err), 1);
        check("to_no_req", 32'(mem_req), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL: run  input  1  level; 1 = fetch/execute enabled, 0 = stop at next instruction boundary.
REQ-004 SHALL: pc_value  input  8  current program-counter value.
REQ-005 SHALL: mem_rdata  input  8  memory read data; valid when mem_ack=1.
REQ-006 SHALL: mem_ack  input  1  memory read-complete strobe.
REQ-007 SHALL: alu_zero  input  1  accumulator-zero flag.
REQ-008 SHALL: mem_req  output  1  read request.
REQ-009 SHALL: mem_addr  output  8  read address.
REQ-010 SHALL: pc_inc  output  1  one-cycle PC increment strobe.
REQ-011 SHALL: pc_load  output  1  one-cycle PC load strobe.
REQ-012 SHALL: pc_dat  output  8  PC load value.
REQ-013 SHALL: ir  output  8  instruction register.
REQ-014 SHALL: operand  output  8  operand register.
REQ-015 SHALL: acc_we  output  1  one-cycle accumulator write strobe.
REQ-016 SHALL: alu_op  output  2  00 pass operand, 01 add, 10 sub; don't-care when acc_we=0.
REQ-017 SHALL: halted  output  1  high in HALT state.

Function
REQ-018 SHALL: implement states IDLE, FETCH, DECODE, OPER, EXEC, HALT.
REQ-019 SHALL: opcode = ir[7:4]; 0x0 NOP, 0x1 ADD imm, 0x2 SUB imm, 0x3 LDI imm, 0x4 JMP addr, 0x5 JZ addr, 0xF HLT; any other opcode executes as NOP.
REQ-020 SHALL: IDLE -> FETCH when run=1; otherwise remain in IDLE.
REQ-021 SHALL: in FETCH and OPER, drive mem_req=1 and mem_addr=pc_value every cycle until mem_ack=1 (ack may arrive any number of cycles later, including in the first cycle).
REQ-022 SHALL: in FETCH with mem_ack=1, latch ir<=mem_rdata, pulse pc_inc, and go to DECODE.
REQ-023 SHALL: in DECODE, go to OPER for opcodes 0x1-0x5; go to EXEC for all others.
REQ-024 SHALL: in OPER with mem_ack=1, latch operand<=mem_rdata, pulse pc_inc, and go to EXEC.
REQ-025 SHALL: in EXEC, for ADD/SUB/LDI, pulse acc_we with alu_op 01/10/00 respectively.
REQ-026 SHALL: in EXEC, for JMP, pulse pc_load with pc_dat=operand.
REQ-027 SHALL: in EXEC, for JZ, pulse pc_load with pc_dat=operand only if alu_zero=1, sampled in the EXEC cycle.
REQ-028 SHALL: in EXEC, for HLT, go to HALT; for every other opcode, go to FETCH if run=1, else to IDLE.
REQ-029 SHALL: HALT is absorbing; only rst leaves it.
REQ-030 SHALL: pc_inc and pc_load never be high in the same cycle.
REQ-031 SHALL: mem_req be 0 outside FETCH/OPER, and mem_ack be ignored outside those states.
REQ-032 SHALL: deassertion of run mid-instruction take effect only at the EXEC exit decision.
REQ-033 SHALL: pc_value arithmetic wrap (0xFF -> 0x00) be transparent; the sequencer performs no address arithmetic.
REQ-034 SHALL: minimum instruction latency be 3 cycles for 1-byte and 4 cycles for 2-byte instructions, with zero-wait ack.

Reset
REQ-035 SHALL: on rst=1, immediately enter IDLE, set ir=0x00 and operand=0x00, and force mem_req, pc_inc, pc_load, acc_we and halted to 0, with pc_dat=0x00 and alu_op=00.
REQ-036 SHALL: on rst assertion mid-FETCH/OPER, drop mem_req asynchronously and discard the pending read.

Configuration
REQ-037 SHALL: when SEQ_TIMEOUT_EN is defined, add output mem_err (1 bit) and a 4-bit wait counter cleared on entry to FETCH/OPER; after 15 consecutive cycles of mem_req without mem_ack, enter HALT with mem_err=1; mem_err is cleared only by rst.
REQ-038 SHALL: when SEQ_TIMEOUT_EN is undefined, omit mem_err and wait for ack indefinitely.

Verification
REQ-039 SHALL: run=1, zero-wait memory returning 0x31, 0x05 at pc 0x00/0x01 -> ir=0x31, operand=0x05, two pc_inc pulses, acc_we with alu_op=00 on the 4th cycle after IDLE exit.
REQ-040 SHALL: JZ (0x50, 0x20) with alu_zero=1 -> pc_load with pc_dat=0x20; with alu_zero=0 -> no pc_load, next fetch at pc_value.
REQ-041 SHALL: fetch of 0xF0 -> halted=1 permanently with mem_req=0, despite run toggling; rst -> IDLE.
REQ-042 SHALL: ack delayed 7 cycles -> mem_req held 7 cycles with mem_addr stable, exactly one pc_inc.
REQ-043 SHALL: rst pulse during OPER -> same-cycle mem_req=0, all outputs at reset values.
REQ-044 SHALL: with SEQ_TIMEOUT_EN defined and ack never given -> mem_err=1 and halted=1 after 15 request cycles.
